// File: rtl/axi_ram_slv.sv
`timescale 1ns/1ps
// AXI4 responder backed by a 32-bit word RAM; independent single-outstanding
// write and read channels, FIXED/INCR bursts, SLVERR for WRAP or non-word size.
module axi_ram_slv #(
    parameter int unsigned ADDR_W    = 12,
    parameter bit          INIT_ZERO = 1'b1
) (
    input  logic              aclk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] s_axi_awaddr,
    input  logic [7:0]        s_axi_awlen,
    input  logic [2:0]        s_axi_awsize,
    input  logic [1:0]        s_axi_awburst,
    input  logic              s_axi_awlock,
    input  logic [3:0]        s_axi_awcache,
    input  logic [2:0]        s_axi_awprot,
    input  logic              s_axi_awvalid,
    output logic              s_axi_awready,
    input  logic [31:0]       s_axi_wdata,
    input  logic [3:0]        s_axi_wstrb,
    input  logic              s_axi_wlast,
    input  logic              s_axi_wvalid,
    output logic              s_axi_wready,
    output logic [1:0]        s_axi_bresp,
    output logic              s_axi_bvalid,
    input  logic              s_axi_bready,
    input  logic [ADDR_W-1:0] s_axi_araddr,
    input  logic [7:0]        s_axi_arlen,
    input  logic [2:0]        s_axi_arsize,
    input  logic [1:0]        s_axi_arburst,
    input  logic              s_axi_arlock,
    input  logic [3:0]        s_axi_arcache,
    input  logic [2:0]        s_axi_arprot,
    input  logic              s_axi_arvalid,
    output logic              s_axi_arready,
    output logic [31:0]       s_axi_rdata,
    output logic [1:0]        s_axi_rresp,
    output logic              s_axi_rlast,
    output logic              s_axi_rvalid,
    input  logic              s_axi_rready
);
    localparam int unsigned WORD_W = ADDR_W - 2;
    localparam int unsigned DEPTH  = 1 << WORD_W;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [2:0] SIZE_WORD   = 3'd2;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} r_state_t;

    // Storage; the declaration value only models the power-up contents in simulation
    logic [31:0] mem [DEPTH] = '{default: (INIT_ZERO ? 32'h0 : 32'hx)};

    w_state_t          w_state, w_state_nxt;
    logic [WORD_W-1:0] w_addr;
    logic [7:0]        w_len, w_cnt;
    logic              w_fixed, w_err, w_done;

    r_state_t          r_state, r_state_nxt;
    logic [WORD_W-1:0] r_addr;
    logic [7:0]        r_len, r_cnt;
    logic              r_fixed, r_err;

    logic aw_hs_c, w_hs_c, w_we_c, ar_hs_c;
    logic unused_ok;

    assign aw_hs_c = s_axi_awvalid && s_axi_awready;
    assign w_hs_c  = s_axi_wvalid && s_axi_wready;
    assign ar_hs_c = s_axi_arvalid && s_axi_arready;
    // Beats past awlen, or of an erroneous burst, are accepted but not stored
    assign w_we_c  = w_hs_c && !w_err && !w_done;

    assign unused_ok = ^{s_axi_awlock, s_axi_awcache, s_axi_awprot, s_axi_awaddr[1:0],
                         s_axi_arlock, s_axi_arcache, s_axi_arprot, s_axi_araddr[1:0]};

    // Write channel next-state
    always_comb begin
        w_state_nxt = w_state;
        case (w_state)
            W_IDLE:  if (aw_hs_c) w_state_nxt = W_DATA;
            W_DATA:  if (w_hs_c && s_axi_wlast) w_state_nxt = W_RESP;
            W_RESP:  if (s_axi_bready) w_state_nxt = W_IDLE;
            default: w_state_nxt = W_IDLE;
        endcase
    end

    // Write channel state, burst tracking and registered handshake outputs
    always_ff @(posedge aclk or posedge rst) begin
        if (rst) begin
            w_state       <= W_IDLE;
            w_addr        <= '0;
            w_len         <= '0;
            w_cnt         <= '0;
            w_fixed       <= 1'b0;
            w_err         <= 1'b0;
            w_done        <= 1'b0;
            s_axi_awready <= 1'b1;
            s_axi_wready  <= 1'b0;
            s_axi_bvalid  <= 1'b0;
            s_axi_bresp   <= RESP_OKAY;
        end else begin
            w_state       <= w_state_nxt;
            s_axi_awready <= (w_state_nxt == W_IDLE);
            s_axi_wready  <= (w_state_nxt == W_DATA);
            s_axi_bvalid  <= (w_state_nxt == W_RESP);
            if (aw_hs_c) begin
                w_addr  <= s_axi_awaddr[ADDR_W-1:2];
                w_len   <= s_axi_awlen;
                w_cnt   <= '0;
                w_fixed <= (s_axi_awburst == BURST_FIXED);
                w_err   <= (s_axi_awsize != SIZE_WORD) || (s_axi_awburst == BURST_WRAP);
                w_done  <= 1'b0;
            end else if (w_hs_c) begin
                w_cnt <= w_cnt + 8'd1;
                if (!w_fixed) w_addr <= w_addr + WORD_W'(1);
                if (w_cnt == w_len) w_done <= 1'b1;
                if (s_axi_wlast) begin
                    if (w_cnt != w_len || w_done) w_err <= 1'b1;
                    s_axi_bresp <= (w_err || w_done || w_cnt != w_len) ? RESP_SLVERR : RESP_OKAY;
                end
            end
        end
    end

    // RAM write port with byte-lane enables
    always_ff @(posedge aclk) begin
        if (w_we_c) begin
            for (int b = 0; b < 4; b++) begin
                if (s_axi_wstrb[b]) mem[w_addr][8*b +: 8] <= s_axi_wdata[8*b +: 8];
            end
        end
    end

    // Read channel next-state
    always_comb begin
        r_state_nxt = r_state;
        case (r_state)
            R_IDLE:  if (ar_hs_c) r_state_nxt = R_FETCH;
            R_FETCH: r_state_nxt = R_DATA;
            R_DATA:  if (s_axi_rready) r_state_nxt = s_axi_rlast ? R_IDLE : R_FETCH;
            default: r_state_nxt = R_IDLE;
        endcase
    end

    // Read channel state, RAM read register (read-first) and R payload
    always_ff @(posedge aclk or posedge rst) begin
        if (rst) begin
            r_state       <= R_IDLE;
            r_addr        <= '0;
            r_len         <= '0;
            r_cnt         <= '0;
            r_fixed       <= 1'b0;
            r_err         <= 1'b0;
            s_axi_arready <= 1'b1;
            s_axi_rvalid  <= 1'b0;
            s_axi_rlast   <= 1'b0;
            s_axi_rresp   <= RESP_OKAY;
            s_axi_rdata   <= '0;
        end else begin
            r_state       <= r_state_nxt;
            s_axi_arready <= (r_state_nxt == R_IDLE);
            s_axi_rvalid  <= (r_state_nxt == R_DATA);
            if (ar_hs_c) begin
                r_addr  <= s_axi_araddr[ADDR_W-1:2];
                r_len   <= s_axi_arlen;
                r_cnt   <= '0;
                r_fixed <= (s_axi_arburst == BURST_FIXED);
                r_err   <= (s_axi_arsize != SIZE_WORD) || (s_axi_arburst == BURST_WRAP);
            end
            if (r_state == R_FETCH) begin
                s_axi_rdata <= r_err ? 32'h0 : mem[r_addr];
                s_axi_rresp <= r_err ? RESP_SLVERR : RESP_OKAY;
                s_axi_rlast <= (r_cnt == r_len);
            end
            if (r_state == R_DATA && s_axi_rready && !s_axi_rlast) begin
                r_cnt <= r_cnt + 8'd1;
                if (!r_fixed) r_addr <= r_addr + WORD_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_axi_ram_slv.sv
`timescale 1ns/1ps
// Scoreboard bench for axi_ram_slv: tasks queue expected B/R responses, a
// negedge monitor pops and compares them as the DUT presents them.
module tb_axi_ram_slv;
    localparam int unsigned ADDR_W = 12;

    logic              aclk = 1'b0;
    logic              rst;
    logic [ADDR_W-1:0] awaddr, araddr;
    logic [7:0]        awlen, arlen;
    logic [2:0]        awsize, arsize, awprot, arprot;
    logic [1:0]        awburst, arburst, bresp, rresp;
    logic              awlock, arlock;
    logic [3:0]        awcache, arcache, wstrb;
    logic              awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic              arvalid, arready, rlast, rvalid, rready;
    logic [31:0]       wdata, rdata;

    axi_ram_slv #(.ADDR_W(ADDR_W), .INIT_ZERO(1'b1)) dut (
        .aclk(aclk), .rst(rst),
        .s_axi_awaddr(awaddr), .s_axi_awlen(awlen), .s_axi_awsize(awsize),
        .s_axi_awburst(awburst), .s_axi_awlock(awlock), .s_axi_awcache(awcache),
        .s_axi_awprot(awprot), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
        .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wlast(wlast),
        .s_axi_wvalid(wvalid), .s_axi_wready(wready),
        .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
        .s_axi_araddr(araddr), .s_axi_arlen(arlen), .s_axi_arsize(arsize),
        .s_axi_arburst(arburst), .s_axi_arlock(arlock), .s_axi_arcache(arcache),
        .s_axi_arprot(arprot), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
        .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rlast(rlast),
        .s_axi_rvalid(rvalid), .s_axi_rready(rready)
    );

    always #5 aclk = ~aclk;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
    } rexp_t;

    logic [1:0]  bq [$];
    rexp_t       rq [$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] wd [16];
    logic [3:0]  ws [16];
    logic [31:0] rd_exp [16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compare every B/R handshake against the scoreboard queues
    rexp_t r_hold;
    logic  r_stall = 1'b0;
    always @(negedge aclk) begin
        rexp_t e;
        if (rst) begin
            r_stall = 1'b0;
        end else begin
            if (bvalid && bready) begin
                if (bq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_b: bresp=%0b with no write pending", bresp);
                end else begin
                    check("bresp", 32'(bresp), 32'(bq.pop_front()));
                end
            end
            if (rvalid) begin
                if (r_stall) begin
                    check("r_stall_data", rdata, r_hold.data);
                    check("r_stall_last", 32'(rlast), 32'(r_hold.last));
                end
                if (rready) begin
                    if (rq.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_r: rdata=0x%08h with no read pending", rdata);
                    end else begin
                        e = rq.pop_front();
                        check("rdata", rdata, e.data);
                        check("rresp", 32'(rresp), 32'(e.resp));
                        check("rlast", 32'(rlast), 32'(e.last));
                    end
                    r_stall = 1'b0;
                end else begin
                    r_stall = 1'b1;
                    r_hold  = '{rdata, rresp, rlast};
                end
            end else begin
                r_stall = 1'b0;
            end
        end
    end

    // Wait for a ready (0=aw,1=w,2=ar) sampled high at a clock edge
    task automatic wait_hs(input string name, input int which);
        logic hs;
        int n = 0;
        do begin
            @(negedge aclk);
            hs = (which == 0) ? awready : (which == 1) ? wready : arready;
            @(posedge aclk);
            #1;
            n++;
        end while (!hs && n < 100);
        if (!hs) begin
            checks++; errors++;
            $display("FAIL %s_timeout: no handshake after %0d cycles", name, n);
        end
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while ((bq.size() != 0 || rq.size() != 0) && n < 300) begin
            @(posedge aclk);
            #1;
            n++;
        end
        if (bq.size() != 0 || rq.size() != 0) begin
            checks++; errors++;
            $display("FAIL %s_drain: %0d B and %0d R responses still pending", name, bq.size(), rq.size());
            bq.delete();
            rq.delete();
        end
    endtask

    task automatic write_burst(input logic [11:0] a, input logic [7:0] len, input logic [2:0] sz,
                               input logic [1:0] bt, input int nb, input logic [1:0] exp_resp);
        bq.push_back(exp_resp);
        awaddr = a; awlen = len; awsize = sz; awburst = bt; awvalid = 1'b1;
        wait_hs("aw", 0);
        awvalid = 1'b0;
        for (int i = 0; i < nb; i++) begin
            wdata = wd[i]; wstrb = ws[i]; wlast = (i == nb - 1); wvalid = 1'b1;
            wait_hs("w", 1);
        end
        wvalid = 1'b0; wlast = 1'b0;
        wait_drain("write");
    endtask

    task automatic write1(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s);
        wd[0] = d; ws[0] = s;
        write_burst(a, 8'd0, 3'd2, 2'b01, 1, 2'b00);
    endtask

    task automatic read_burst(input logic [11:0] a, input logic [7:0] len, input logic [2:0] sz,
                              input logic [1:0] bt, input logic [1:0] exp_resp, input int stall_after);
        int n = 0;
        int total = int'(len) + 1;
        for (int i = 0; i < total; i++) rq.push_back('{rd_exp[i], exp_resp, 1'(i == total - 1)});
        araddr = a; arlen = len; arsize = sz; arburst = bt; arvalid = 1'b1;
        wait_hs("ar", 2);
        arvalid = 1'b0;
        if (stall_after >= 0) begin
            while (rq.size() > total - stall_after && n < 100) begin
                @(posedge aclk);
                #1;
                n++;
            end
            rready = 1'b0;
            repeat (5) @(posedge aclk);
            #1;
            rready = 1'b1;
        end
        wait_drain("read");
    endtask

    task automatic read1(input logic [11:0] a, input logic [31:0] d);
        rd_exp[0] = d;
        read_burst(a, 8'd0, 3'd2, 2'b01, 2'b00, -1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        awaddr = '0; awlen = '0; awsize = 3'd2; awburst = 2'b01; awlock = 1'b0; awcache = '0;
        awprot = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0;
        bready = 1'b1; araddr = '0; arlen = '0; arsize = 3'd2; arburst = 2'b01; arlock = 1'b0;
        arcache = '0; arprot = '0; arvalid = 1'b0; rready = 1'b1;
        repeat (3) @(posedge aclk);
        #1;
        check("rst_awready", 32'(awready), 32'd1);
        check("rst_arready", 32'(arready), 32'd1);
        check("rst_wready", 32'(wready), 32'd0);
        check("rst_bvalid", 32'(bvalid), 32'd0);
        check("rst_rvalid", 32'(rvalid), 32'd0);
        check("rst_rlast", 32'(rlast), 32'd0);
        check("rst_bresp", 32'(bresp), 32'd0);
        check("rst_rresp", 32'(rresp), 32'd0);
        check("rst_rdata", rdata, 32'd0);
        rst = 1'b0;
        @(posedge aclk);
        #1;

        // Single write then read
        write1(12'hFEC, 32'h1234ABCD, 4'hF);
        read1(12'hFEC, 32'h1234ABCD);

        // INCR burst write and read, then re-read with a 5-cycle rready stall
        wd[0] = 32'hFEDCBA98; wd[1] = 32'h01234567; wd[2] = 32'hAAAAAAAA; wd[3] = 32'hFFFFFFFF;
        for (int i = 0; i < 4; i++) ws[i] = 4'hF;
        write_burst(12'h000, 8'd3, 3'd2, 2'b01, 4, 2'b00);
        for (int i = 0; i < 4; i++) rd_exp[i] = wd[i];
        read_burst(12'h000, 8'd3, 3'd2, 2'b01, 2'b00, -1);
        read_burst(12'h000, 8'd3, 3'd2, 2'b01, 2'b00, 2);

        // Byte strobes
        write1(12'h010, 32'hFFFFFFFF, 4'hF);
        write1(12'h010, 32'h00000000, 4'b0101);
        read1(12'h010, 32'hFF00FF00);

        // INCR wraps from the top word to word 0, on write and on read
        wd[0] = 32'hCAFE0001; wd[1] = 32'hCAFE0002; ws[0] = 4'hF; ws[1] = 4'hF;
        write_burst(12'hFFC, 8'd1, 3'd2, 2'b01, 2, 2'b00);
        read1(12'h000, 32'hCAFE0002);
        rd_exp[0] = 32'hCAFE0001; rd_exp[1] = 32'hCAFE0002;
        read_burst(12'hFFC, 8'd1, 3'd2, 2'b01, 2'b00, -1);

        // FIXED burst keeps hitting one word
        wd[0] = 32'h1; wd[1] = 32'h2; wd[2] = 32'h3;
        for (int i = 0; i < 3; i++) ws[i] = 4'hF;
        write_burst(12'h020, 8'd2, 3'd2, 2'b00, 3, 2'b00);
        read1(12'h020, 32'h3);
        read1(12'h024, 32'h0);

        // Bad size: beats swallowed, RAM untouched
        wd[0] = 32'h55555555; wd[1] = 32'h66666666; ws[0] = 4'hF; ws[1] = 4'hF;
        write_burst(12'h030, 8'd1, 3'd1, 2'b01, 2, 2'b10);
        read1(12'h030, 32'h0);
        read1(12'h034, 32'h0);

        // WRAP read returns SLVERR with zero data
        rd_exp[0] = 32'h0; rd_exp[1] = 32'h0;
        read_burst(12'hFEC, 8'd1, 3'd2, 2'b10, 2'b10, -1);

        // Early wlast
        wd[0] = 32'h77777777; wd[1] = 32'h88888888; ws[0] = 4'hF; ws[1] = 4'hF;
        write_burst(12'h040, 8'd3, 3'd2, 2'b01, 2, 2'b10);

        // Reset in the middle of a len=7 write
        awaddr = 12'h050; awlen = 8'd7; awsize = 3'd2; awburst = 2'b01; awvalid = 1'b1;
        wait_hs("aw", 0);
        awvalid = 1'b0;
        wd[0] = 32'h11111111; wd[1] = 32'h22222222;
        for (int i = 0; i < 2; i++) begin
            wdata = wd[i]; wstrb = 4'hF; wlast = 1'b0; wvalid = 1'b1;
            wait_hs("w", 1);
        end
        wdata = 32'h33333333; wvalid = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        check("abort_awready", 32'(awready), 32'd1);
        check("abort_wready", 32'(wready), 32'd0);
        check("abort_bvalid", 32'(bvalid), 32'd0);
        check("abort_arready", 32'(arready), 32'd1);
        check("abort_rvalid", 32'(rvalid), 32'd0);
        wvalid = 1'b0;
        @(posedge aclk);
        #1;
        rst = 1'b0;
        repeat (3) begin
            @(negedge aclk);
            check("abort_no_b", 32'(bvalid), 32'd0);
        end
        @(posedge aclk);
        #1;
        write1(12'h060, 32'h600D600D, 4'hF);
        read1(12'h060, 32'h600D600D);
        rd_exp[0] = 32'h11111111; rd_exp[1] = 32'h22222222;
        read_burst(12'h050, 8'd1, 3'd2, 2'b01, 2'b00, -1);
        read1(12'h058, 32'h0);

        repeat (3) @(posedge aclk);
        check("final_bq_empty", 32'(bq.size()), 32'd0);
        check("final_rq_empty", 32'(rq.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
